// File: rtl/paralelo_serial_pkg.sv
// Shared constants and helpers for the parallel-to-serial transmit path.
package paralelo_serial_pkg;

    // K28.5 comma character, sent on the line whenever no data is queued.
    localparam logic [7:0] COM_K28_5 = 8'hBC;

    // Serialisation order of a frame.
    typedef enum logic {
        BIT_LSB_FIRST = 1'b0,
        BIT_MSB_FIRST = 1'b1
    } bit_order_e;

    // Width of a counter that must hold every value 0..depth.
    function automatic int count_width(input int depth);
        return (depth < 1) ? 1 : $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/paralelo_serial_param_if.sv
// Word-input handshake: the source drives data/valid, the converter answers with ready.
interface paralelo_serial_param_if #(
    parameter int WIDTH = 8
);
    logic [WIDTH-1:0] data_in;
    logic             valid_in;
    logic             ready_out;

    modport master (output data_in, output valid_in, input ready_out);
    modport slave  (input data_in, input valid_in, output ready_out);
endinterface

// File: rtl/paralelo_serial_fifo.sv
// Synchronous FIFO feeding the serialiser; no bypass, head is the registered oldest entry.
module paralelo_serial_fifo
    import paralelo_serial_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           push,
    input  logic [WIDTH-1:0]               push_data,
    input  logic                           pop,
    output logic [WIDTH-1:0]               head,
    output logic [count_width(DEPTH)-1:0]  count,
    output logic                           full
);
    localparam int PW = $clog2(DEPTH);
    localparam int CNT_W = count_width(DEPTH);

    logic [DEPTH-1:0][WIDTH-1:0] mem;
    logic [PW-1:0]               wr_ptr;
    logic [PW-1:0]               rd_ptr;
    logic                        push_ok;
    logic                        pop_ok;

    // Ignore requests that would overflow or underflow rather than corrupt state.
    assign push_ok = push && !full;
    assign pop_ok  = pop && (count != '0);
    assign full    = (count == CNT_W'(DEPTH));
    assign head    = mem[rd_ptr];

    // Storage needs no reset; only entries counted as occupied are ever read.
    always_ff @(posedge clk) begin
        if (push_ok)
            mem[wr_ptr] <= push_data;
    end

    // Pointers wrap naturally (DEPTH is a power of two); push+pop keeps count.
    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
            case ({push_ok, pop_ok})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/paralelo_serial_param.sv
// Parallel-to-serial converter: queues words and emits back-to-back WIDTH-bit
// frames on data_out, filling empty slots with the COM idle character.
module paralelo_serial_param
    import paralelo_serial_pkg::*;
#(
    parameter int               WIDTH     = 8,
    parameter int               DEPTH     = 4,
    parameter logic [WIDTH-1:0] COM       = WIDTH'(COM_K28_5),
    parameter bit               MSB_FIRST = 1'b1
) (
    input  logic                           clk_32f,
    input  logic                           reset,
    paralelo_serial_param_if.slave         in_if,
    output logic [WIDTH-1:0]               data2send,
    output logic                           data_out,
    output logic                           word_start,
    output logic                           sending_data,
    output logic [count_width(DEPTH)-1:0]  fifo_count
);
    localparam int               CW    = $clog2(WIDTH);
    localparam logic [CW-1:0]    LAST  = CW'(WIDTH - 1);
    localparam bit_order_e       ORDER = MSB_FIRST ? BIT_MSB_FIRST : BIT_LSB_FIRST;
    localparam int               FIRST = (ORDER == BIT_MSB_FIRST) ? WIDTH - 1 : 0;

    logic [CW-1:0]    bit_cnt;
    logic [CW-1:0]    send_idx;
    logic [WIDTH-1:0] head;
    logic             full;
    logic             push;
    logic             pop;
    logic             load;

    // ready is held low during reset so nothing is accepted into a FIFO being cleared.
    assign in_if.ready_out = reset && !full;
    assign push            = in_if.valid_in && in_if.ready_out;
    assign load            = (bit_cnt == '0);
    assign pop             = reset && load && (fifo_count != '0);
    // bit_cnt counts in send order; map it to the physical bit index.
    assign send_idx        = (ORDER == BIT_MSB_FIRST) ? (LAST - bit_cnt) : bit_cnt;

    paralelo_serial_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk_32f),
        .reset     (reset),
        .push      (push),
        .push_data (in_if.data_in),
        .pop       (pop),
        .head      (head),
        .count     (fifo_count),
        .full      (full)
    );

    // Frame sequencer: load a new word (FIFO head or COM) at bit 0, then shift it out.
    always_ff @(posedge clk_32f) begin
        if (!reset) begin
            bit_cnt      <= '0;
            data2send    <= COM;
            data_out     <= 1'b0;
            word_start   <= 1'b0;
            sending_data <= 1'b0;
        end else if (load) begin
            bit_cnt    <= CW'(1);
            word_start <= 1'b1;
            if (fifo_count != '0) begin
                data2send    <= head;
                sending_data <= 1'b1;
                data_out     <= head[FIRST];
            end else begin
                data2send    <= COM;
                sending_data <= 1'b0;
                data_out     <= COM[FIRST];
            end
        end else begin
            data_out   <= data2send[send_idx];
            word_start <= 1'b0;
            bit_cnt    <= (bit_cnt == LAST) ? '0 : bit_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_paralelo_serial_param.sv
// Randomised scoreboard bench for two configurations of paralelo_serial_param:
// 8-bit MSB-first with the default comma, and 10-bit LSB-first with COM=10'h17C.
module tb_paralelo_serial_param;
    import paralelo_serial_pkg::*;

    localparam int DEPTH = 4;
    localparam int NCYC  = 1600;

    typedef struct {
        logic [15:0] w;
        int          stamp;   // edge index at which the word entered the FIFO
    } pkt_t;

    logic clk_32f = 1'b0;
    logic reset   = 1'b0;
    always #5 clk_32f = ~clk_32f;

    paralelo_serial_param_if #(.WIDTH(8))  bus0();
    paralelo_serial_param_if #(.WIDTH(10)) bus1();

    logic [7:0] d2s0;
    logic [9:0] d2s1;
    logic [1:0] dout;
    logic [1:0] wst;
    logic [1:0] snd;
    logic [2:0] cnt0;
    logic [2:0] cnt1;

    paralelo_serial_param #(
        .WIDTH(8), .DEPTH(DEPTH), .COM(8'hBC), .MSB_FIRST(1'b1)
    ) dut0 (
        .clk_32f(clk_32f), .reset(reset), .in_if(bus0),
        .data2send(d2s0), .data_out(dout[0]), .word_start(wst[0]),
        .sending_data(snd[0]), .fifo_count(cnt0)
    );

    paralelo_serial_param #(
        .WIDTH(10), .DEPTH(DEPTH), .COM(10'h17C), .MSB_FIRST(1'b0)
    ) dut1 (
        .clk_32f(clk_32f), .reset(reset), .in_if(bus1),
        .data2send(d2s1), .data_out(dout[1]), .word_start(wst[1]),
        .sending_data(snd[1]), .fifo_count(cnt1)
    );

    // Reference model state, one slot per configuration.
    int          W[2]    = '{8, 10};
    logic [15:0] COMV[2] = '{16'h00BC, 16'h017C};
    bit          MSBF[2] = '{1'b1, 1'b0};
    pkt_t        sbq[2][$];
    int          pos[2];
    logic [15:0] cur[2];
    bit          cur_d[2];
    int          edge_no = 0;
    int          n_chk   = 0;
    int          n_pass  = 0;

    task automatic chk(input string nm, input int inst, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s[%0d] edge %0d: got %0h expected %0h", nm, inst, edge_no, act, exp);
    endtask

    // Monitor: after every edge, advance the frame-level model and compare.
    initial begin
        int          a_cnt;
        int          a_d2s;
        int          a_rdy;
        int          expb;
        forever begin
            @(posedge clk_32f);
            edge_no++;
            #1;
            for (int i = 0; i < 2; i++) begin
                a_cnt = (i == 0) ? int'(cnt0) : int'(cnt1);
                a_d2s = (i == 0) ? int'(d2s0) : int'(d2s1);
                a_rdy = (i == 0) ? int'(bus0.ready_out) : int'(bus1.ready_out);
                if (!reset) begin
                    // Reset discards queued words and any partial frame.
                    pos[i] = 0;
                    sbq[i].delete();
                    chk("rst_data_out", i, int'(dout[i]), 0);
                    chk("rst_word_start", i, int'(wst[i]), 0);
                    chk("rst_sending", i, int'(snd[i]), 0);
                    chk("rst_data2send", i, a_d2s, int'(COMV[i]));
                    chk("rst_count", i, a_cnt, 0);
                    chk("rst_ready", i, a_rdy, 0);
                end else begin
                    if (pos[i] == 0) begin
                        // A word is sent only if it was queued before this frame boundary.
                        if (sbq[i].size() > 0 && sbq[i][0].stamp < edge_no) begin
                            cur[i]   = sbq[i].pop_front().w;
                            cur_d[i] = 1'b1;
                        end else begin
                            cur[i]   = COMV[i];
                            cur_d[i] = 1'b0;
                        end
                    end
                    expb = int'(cur[i][MSBF[i] ? (W[i] - 1 - pos[i]) : pos[i]]);
                    chk("data_out", i, int'(dout[i]), expb);
                    chk("word_start", i, int'(wst[i]), (pos[i] == 0) ? 1 : 0);
                    chk("sending_data", i, int'(snd[i]), int'(cur_d[i]));
                    chk("data2send", i, a_d2s, int'(cur[i]));
                    chk("fifo_count", i, a_cnt, sbq[i].size());
                    chk("ready_out", i, a_rdy, (sbq[i].size() < DEPTH) ? 1 : 0);
                    pos[i] = (pos[i] + 1) % W[i];
                end
            end
        end
    end

    // Driver: random valid/data per phase, holding a refused word until accepted.
    initial begin
        bit          vin[2];
        bit          acc[2];
        logic [15:0] din[2];
        int          p;
        for (int i = 0; i < 2; i++) begin
            vin[i] = 1'b0;
            acc[i] = 1'b0;
            din[i] = '0;
        end
        bus0.valid_in = 1'b0;
        bus0.data_in  = '0;
        bus1.valid_in = 1'b0;
        bus1.data_in  = '0;
        for (int c = 0; c < NCYC; c++) begin
            @(negedge clk_32f);
            reset = !(c < 3 || c == 600 || c == 1100 || c == 1101);
            p = (c < 200) ? 15 : (c < 500) ? 95 : (c < 1000) ? 45 : (c < 1450) ? 20 : 0;
            for (int i = 0; i < 2; i++) begin
                if (!(vin[i] && !acc[i])) begin
                    if (c == 3) begin
                        vin[i] = 1'b1;
                        din[i] = (i == 0) ? 16'h00A5 : 16'h0283;
                    end else begin
                        vin[i] = ($urandom_range(99) < p);
                        din[i] = 16'($urandom_range(0, (1 << W[i]) - 1));
                    end
                end
            end
            bus0.valid_in = vin[0];
            bus0.data_in  = din[0][7:0];
            bus1.valid_in = vin[1];
            bus1.data_in  = din[1][9:0];
            #1;
            acc[0] = vin[0] && bus0.ready_out;
            acc[1] = vin[1] && bus1.ready_out;
            for (int i = 0; i < 2; i++)
                if (acc[i]) sbq[i].push_back('{din[i], edge_no + 1});
        end
        @(negedge clk_32f);
        chk("drained", 0, sbq[0].size(), 0);
        chk("drained", 1, sbq[1].size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/paralelo_serial_param.md
# paralelo_serial_param

Parametrised single-clock parallel-to-serial converter: accepts WIDTH-bit words through a valid/ready handshake into a DEPTH-entry FIFO and shifts them out one bit per clk_32f cycle. When no data is queued, it inserts the COM idle character so the serial line always carries aligned WIDTH-bit frames. This block succeeds the two-clock 8-bit paralelo_serial in the transmit path. The clk_4f domain is removed: word boundaries come from an internal bit counter.

## Interface
- WIDTH, 8, word width in bits (≥2)
- DEPTH, 4, input FIFO entries (power of 2, ≥2)
- COM, 8'hBC (WIDTH bits), idle character sent when FIFO is empty
- MSB_FIRST, 1, 1 = send bit WIDTH-1 first; 0 = send bit 0 first
- clk_32f  in  1  bit clock; all logic is on its rising edge
- reset  in  1  synchronous, active-low
- data_in  in  WIDTH  parallel word
- valid_in  in  1  data_in is valid
- ready_out  out  1  FIFO can accept a word this cycle
- data2send  out  WIDTH  word currently being serialised (FIFO word or COM)
- data_out  out  1  serial bit
- word_start  out  1  high while data_out carries the first bit of a frame
- sending_data  out  1  high while the current frame came from the FIFO (low for COM)
- fifo_count  out  $clog2(DEPTH+1)  number of occupied FIFO entries

## Operation
- Reset (reset==0 at an edge) does the following:
  - sets bit_cnt to 0 and data2send to COM;
  - sets data_out, word_start and sending_data to 0;
  - empties the FIFO (fifo_count 0, pointers 0).
- ready_out = reset && (fifo_count < DEPTH). It is combinational from the registered count and is 0 while reset is low.
- Push: on any edge with valid_in && ready_out, data_in is written at the tail. With valid_in high and ready_out low, the word is ignored. The source must hold the word.
- Load edge: any edge with bit_cnt==0 and reset==1.
  - If fifo_count>0, pop the head into data2send and set sending_data=1. Otherwise load COM and set sending_data=0.
  - data_out takes the first bit of the new word: bit WIDTH-1 if MSB_FIRST, else bit 0.
  - word_start=1 and bit_cnt=1.
- Shift edge: any other edge with reset==1.
  - data_out takes bit index bit_cnt of data2send, counted in send order.
  - word_start=0.
  - bit_cnt increments and wraps from WIDTH-1 to 0.
- Each frame occupies exactly WIDTH consecutive data_out cycles. Frames are back-to-back with no gaps.
- A simultaneous push and pop leaves fifo_count unchanged. Pointers wrap modulo DEPTH.
- There is no bypass: a pop only sees entries counted before the edge. A word pushed on a load edge waits for the next frame.
- Reset mid-frame aborts immediately. The partial frame and all queued words are discarded and not resent.

## Timing
- All outputs are registered except ready_out.
- The first edge with reset==1 is a load edge. Frame 0 after reset is COM unless a word was already queued, which is impossible because reset empties the FIFO.
- Minimum latency:
  - A word pushed at edge k into an empty FIFO is popped at the first load edge after k.
  - Its first bit is on data_out after that edge.
  - Worst case is WIDTH cycles plus one edge.
- Throughput is 1 word per WIDTH cycles. The source may burst up to DEPTH words and is then throttled by ready_out.
- When the FIFO is full at a load edge, the pop frees an entry. ready_out rises in the following cycle.

## Structure
- Shared package paralelo_serial_pkg holds:
  - the COM_K28_5 = 8'hBC constant;
  - the bit-order enum/constants (MSB_FIRST/LSB_FIRST);
  - a clog2 helper for the count width.
- Sub-module paralelo_serial_fifo (parameters WIDTH, DEPTH) provides a synchronous FIFO with push, pop, head, count and full. It is reset by the same synchronous active-low reset.
- The top holds the bit counter, the output register, data2send and the frame-select logic.

## Test plan
- Idle after reset:
  - Stimulus: hold reset low for 3 edges, release, valid_in=0.
  - Response: data_out repeats 1,0,1,1,1,1,0,0; word_start pulses every 8 cycles; sending_data=0; fifo_count=0; ready_out=1.
- Single word:
  - Stimulus: push 8'hA5 on the first edge after release.
  - Response: frame 0 is COM; frame 1 is 1,0,1,0,0,1,0,1 with sending_data=1 and data2send=8'hA5; frame 2 is COM.
- Burst and back-pressure (DEPTH=4):
  - Stimulus: hold valid_in with words 8'h01..8'h06.
  - Response: ready_out drops when fifo_count=4; it reasserts one cycle after each pop; all six words are serialised in order with no loss or duplication.
- Mode and width:
  - Stimulus: WIDTH=10, COM=10'h17C, MSB_FIRST=0; push 10'h283.
  - Response: idle frames are 0,0,1,1,1,1,1,0,1,0; the data frame is 1,1,0,0,0,0,0,1,0,1.
- Reset mid-frame:
  - Stimulus: 8'h3C is on its 4th bit with 2 words queued; reset=0 for 1 edge.
  - Response: next edge has data_out=0, fifo_count=0, data2send=8'hBC; after release only COM frames appear.
- Simultaneous push/pop:
  - Stimulus: with fifo_count=2, push on a load edge.
  - Response: fifo_count stays 2; the popped head is serialised and the pushed word is queued at the tail.
